// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with jump/branch redirect and a one-cycle IF/ID flush.
// Optional redirect counter enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0] RedirectCount
`endif
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;
    logic redirect;
    logic [31:0] target, pc_next;
    assign PCPlus4 = PC + 32'd4;
    // Redirect requests on the FLUSH cycle come from the killed instruction.
    assign redirect = (state == RUN) && (Jump || BranchTaken);
    assign target = Jump ? JumpTarget : BranchTarget;
    assign pc_next = redirect ? {target[31:2], 2'b00} : Stall ? PC : PCPlus4;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= RUN;
            PC <= {RESET_PC[31:2], 2'b00};
        end else begin
            state <= state_next;
            PC <= pc_next;
        end
    end
    always_comb begin
        state_next = RUN;
        if (state == RUN && redirect) state_next = FLUSH;
    end
    always_comb begin
        Flush = (state == FLUSH);
    end
`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) RedirectCount <= 32'd0;
        else if (redirect) RedirectCount <= RedirectCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vectors; expected PC/Flush pushed per cycle, checked by a monitor.
module tb_pc_redirect_unit;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'd0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Flush;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] RedirectCount;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;

    pc_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .PC(PC),
        .PCPlus4(PCPlus4),
        .Flush(Flush)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .RedirectCount(RedirectCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, " PC"}, PC, e.pc);
        chk({tag, " PCPlus4"}, PCPlus4, e.pc + 32'd4);
        chk({tag, " Flush"}, {31'd0, Flush}, {31'd0, e.fl});
`ifdef PC_REDIRECT_STATS_EN
        chk({tag, " RedirectCount"}, RedirectCount, e.cnt);
`endif
    endtask

    // Drives one cycle of inputs at the negedge and queues what PC/Flush must be after the next edge.
    task automatic step(input logic st, input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jt,
                        input logic [31:0] epc, input logic ef, input logic [31:0] ecnt);
        exp_t e;
        Stall = st; BranchTaken = bt; BranchTarget = btg; Jump = j; JumpTarget = jt;
        e.pc = epc; e.fl = ef; e.cnt = ecnt;
        q.push_back(e);
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        #1;
        if (q.size() > 0) check_all("cycle", q.pop_front());
    end

    initial begin
        exp_t r;
        r.pc = 32'h0; r.fl = 1'b0; r.cnt = 32'd0;
        #2;
        check_all("reset", r);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        step(0, 0, 32'h0,   0, 32'h0,   32'h4,   0, 0);
        step(0, 0, 32'h0,   0, 32'h0,   32'h8,   0, 0);
        step(0, 0, 32'h0,   0, 32'h0,   32'hC,   0, 0);
        step(0, 0, 32'h0,   0, 32'h0,   32'h10,  0, 0);
        step(0, 1, 32'h40,  0, 32'h0,   32'h40,  1, 1);
        step(0, 1, 32'h80,  0, 32'h0,   32'h44,  0, 1);
        step(1, 0, 32'h0,   0, 32'h0,   32'h44,  0, 1);
        step(1, 0, 32'h0,   0, 32'h0,   32'h44,  0, 1);
        step(1, 1, 32'h40,  1, 32'h100, 32'h100, 1, 2);
        step(1, 0, 32'h0,   1, 32'h200, 32'h100, 0, 2);
        step(0, 0, 32'h0,   1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 3);
        step(0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 3);
        step(0, 1, 32'h23,  0, 32'h0,   32'h20,  1, 4);
        #1;
        Rst_n = 1'b0;
        #1;
        check_all("midflush_reset", r);
        @(negedge Clk);
        Rst_n = 1'b1;
        step(0, 0, 32'h0,   0, 32'h0,   32'h4,   0, 0);
        step(0, 1, 32'h9,   0, 32'h0,   32'h8,   1, 1);
        step(0, 0, 32'h0,   0, 32'h0,   32'hC,   0, 1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
        n_checks += q.size();
        if (q.size() > 0) $display("FAIL drain: %0d expected entries unchecked, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
